// File: rtl/dac_ramp_envelope.sv
// dac_ramp_envelope: per-channel linear ramp-up/hold/ramp-down gain stage applied to a DAC sample stream.
module dac_ramp_envelope #(
  parameter int STEP_WIDTH = 32,
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable_ramping,
  input  logic                         start_ramp_down,
  input  logic                         run,
  input  logic [STEP_WIDTH-1:0]        ramp_step,
  input  logic signed [DATA_WIDTH-1:0] dac_in,
  input  logic                         dac_in_valid,
  output logic signed [DATA_WIDTH-1:0] dac_out,
  output logic                         dac_out_valid,
  output logic [1:0]                   ramp_state,
  output logic [15:0]                  ramp_factor,
  output logic                         ramp_done
);
  typedef enum logic [1:0] {IDLE, RAMP_UP, HOLD, RAMP_DOWN} state_t;
  localparam logic [STEP_WIDTH-1:0] FULL = {1'b1, {(STEP_WIDTH-1){1'b0}}};
  localparam int PW = DATA_WIDTH + 18;
  state_t state, state_n;
  logic [STEP_WIDTH-1:0] acc, acc_n;
  logic [STEP_WIDTH:0] sum;
  logic armed, armed_n, done_n, v1;
  logic signed [PW-1:0] prod, prod_q;
  // extra carry bit keeps the ramp-up sum from wrapping past full scale
  assign sum = {1'b0, acc} + {1'b0, ramp_step};
  assign ramp_state = state;
  assign prod = PW'($signed(dac_in)) * PW'($signed({1'b0, ramp_factor}));
  always_comb begin
    state_n = state;
    acc_n = acc;
    armed_n = armed | ~run;
    done_n = 1'b0;
    if (!enable_ramping) begin
      state_n = IDLE;
      acc_n = '0;
      armed_n = 1'b1;
    end else if (state != IDLE && !run) begin
      state_n = IDLE;
      acc_n = '0;
    end else begin
      case (state)
        IDLE: if (run && armed && !start_ramp_down) begin
          state_n = RAMP_UP;
          armed_n = 1'b0;
        end
        RAMP_UP: begin
          state_n = start_ramp_down ? RAMP_DOWN : (sum >= {1'b0, FULL}) ? HOLD : RAMP_UP;
          acc_n = start_ramp_down ? acc : (sum >= {1'b0, FULL}) ? FULL : sum[STEP_WIDTH-1:0];
        end
        HOLD: begin
          acc_n = FULL;
          state_n = start_ramp_down ? RAMP_DOWN : HOLD;
        end
        RAMP_DOWN: begin
          acc_n = (acc > ramp_step) ? acc - ramp_step : '0;
          state_n = (acc > ramp_step) ? RAMP_DOWN : IDLE;
          done_n = (acc <= ramp_step);
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc <= '0;
      armed <= 1'b1;
      ramp_done <= 1'b0;
      ramp_factor <= '0;
      prod_q <= '0;
      v1 <= 1'b0;
      dac_out <= '0;
      dac_out_valid <= 1'b0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      armed <= armed_n;
      ramp_done <= done_n;
      ramp_factor <= enable_ramping ? acc_n[STEP_WIDTH-1 -: 16] : 16'h8000;
      prod_q <= prod;
      v1 <= dac_in_valid;
      dac_out_valid <= v1;
      if (v1) dac_out <= DATA_WIDTH'(prod_q >>> 15);
    end
  end
endmodule

// File: tb/tb_dac_ramp_envelope.sv
// tb_dac_ramp_envelope: randomized and directed bench with a behavioural envelope model and output scoreboard.
module tb_dac_ramp_envelope;
  localparam longint FULL = 64'h8000_0000;
  typedef struct { longint tag; int val; } exp_t;
  logic clk = 0, reset = 1, en = 1, srd = 0, run = 0, dac_in_valid = 0;
  logic [31:0] step = '0;
  logic signed [15:0] dac_in = '0;
  logic signed [15:0] dac_out;
  logic dac_out_valid, ramp_done;
  logic [1:0] ramp_state;
  logic [15:0] ramp_factor;
  int checks = 0, errors = 0, n;
  bit rand_data = 0;
  int m_st = 0, m_fac = 0;
  longint m_acc = 0, cyc = 0;
  bit m_armed = 1, m_done = 0;
  exp_t q[$];
  exp_t e;

  dac_ramp_envelope #(.STEP_WIDTH(32), .DATA_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .enable_ramping(en), .start_ramp_down(srd), .run(run),
    .ramp_step(step), .dac_in(dac_in), .dac_in_valid(dac_in_valid), .dac_out(dac_out),
    .dac_out_valid(dac_out_valid), .ramp_state(ramp_state), .ramp_factor(ramp_factor),
    .ramp_done(ramp_done));

  always #4 clk = ~clk;

  function automatic void chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // reference: envelope follows the rules with plain integer arithmetic
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_st = 0; m_acc = 0; m_armed = 1; m_fac = 0; m_done = 0;
    end else begin
      if (dac_in_valid) q.push_back('{cyc, int'((longint'(dac_in) * m_fac) >>> 15)});
      m_done = 0;
      if (!en) begin
        m_st = 0; m_acc = 0; m_armed = 1;
      end else if (m_st != 0 && !run) begin
        m_st = 0; m_acc = 0;
      end else if (m_st == 0) begin
        if (run && m_armed && !srd) begin m_st = 1; m_armed = 0; end
      end else if (m_st == 1) begin
        if (srd) m_st = 3;
        else begin
          m_acc = m_acc + longint'(step);
          if (m_acc >= FULL) begin m_acc = FULL; m_st = 2; end
        end
      end else if (m_st == 2) begin
        if (srd) m_st = 3;
      end else begin
        m_acc = (m_acc > longint'(step)) ? m_acc - longint'(step) : 0;
        if (m_acc == 0) begin m_st = 0; m_done = 1; end
      end
      if (!run) m_armed = 1;
      m_fac = en ? int'(m_acc / 65536) : 32'h8000;
    end
    cyc++;
  end

  always @(negedge clk) begin
    chk("state", ramp_state, m_st);
    chk("factor", ramp_factor, m_fac);
    chk("done", ramp_done, m_done);
    if (dac_out_valid) begin
      if (q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        e = q.pop_front();
        chk("latency", cyc, e.tag + 2);
        chk("dac_out", dac_out, e.val);
      end
    end else if (q.size() != 0 && q[0].tag + 2 <= cyc) begin
      e = q.pop_front();
      chk("missing_valid", 0, 1);
    end
  end

  initial forever begin
    @(negedge clk);
    if (rand_data) begin
      dac_in = 16'($urandom);
      dac_in_valid = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_st(input int s, input int maxc, output int cnt);
    cnt = 0;
    while (ramp_state != s && cnt < maxc) begin @(negedge clk); cnt++; end
    if (ramp_state != s) chk("wait_state_timeout", ramp_state, s);
  endtask

  task automatic wait_fac(input int f, input int maxc);
    int c = 0;
    while (ramp_factor != f && c < maxc) begin @(negedge clk); c++; end
    if (ramp_factor != f) chk("wait_factor_timeout", ramp_factor, f);
  endtask

  initial begin
    tick(3);
    chk("rst_dac_out", dac_out, 0);
    chk("rst_valid", dac_out_valid, 0);
    chk("rst_factor", ramp_factor, 0);
    reset = 0; en = 0;
    tick(1);
    chk("bypass_factor", ramp_factor, 16'h8000);
    en = 1; rand_data = 1;
    tick(1);
    step = 32'h0100_0000; run = 1;
    tick(1);
    chk("up_state", ramp_state, 1);
    tick(1);
    chk("first_inc", ramp_factor, 16'h0100);
    wait_st(2, 200, n);
    chk("up_cycles", n, 127);
    chk("hold_factor", ramp_factor, 16'h8000);
    tick(5);
    srd = 1;
    tick(1);
    chk("down_state", ramp_state, 3);
    tick(1);
    chk("first_dec", ramp_factor, 16'h7F00);
    wait_st(0, 200, n);
    chk("down_cycles", n, 127);
    chk("done_pulse", ramp_done, 1);
    srd = 0;
    tick(1);
    chk("done_cleared", ramp_done, 0);
    tick(20);
    chk("no_restart", ramp_state, 0);
    run = 0; tick(2); run = 1; tick(1);
    chk("restart", ramp_state, 1);
    wait_fac(16'h4000, 200);
    srd = 1;
    wait_st(0, 200, n);
    chk("abort_down_cycles", n, 65);
    srd = 0; run = 0; tick(1); run = 1; tick(1);
    wait_fac(16'h4000, 200);
    run = 0;
    tick(1);
    chk("drop_state", ramp_state, 0);
    chk("drop_factor", ramp_factor, 0);
    chk("drop_done", ramp_done, 0);
    run = 1;
    wait_fac(16'h4000, 200);
    step = 0; rand_data = 0;
    tick(1);
    dac_in = 16'sd1000; dac_in_valid = 1;
    tick(1);
    dac_in = -16'sd3;
    tick(1);
    chk("dp_1000", dac_out, 500);
    dac_in_valid = 0;
    tick(1);
    chk("dp_neg3", dac_out, -2);
    tick(3);
    chk("zero_step_state", ramp_state, 1);
    chk("zero_step_factor", ramp_factor, 16'h4000);
    chk("hold_dac_out", dac_out, -2);
    run = 0; tick(1); en = 0; tick(1);
    dac_in = -16'sd32768; dac_in_valid = 1;
    tick(1);
    dac_in_valid = 0;
    tick(1);
    chk("dp_fullscale", dac_out, -32768);
    en = 1; step = 32'hFFFF_FFFF; run = 1;
    tick(1);
    chk("big_step_up", ramp_state, 1);
    tick(1);
    chk("big_step_hold", ramp_state, 2);
    chk("big_step_factor", ramp_factor, 16'h8000);
    run = 0; tick(1);
    step = 32'h0100_0000; run = 1; rand_data = 1;
    tick(10);
    reset = 1;
    tick(1);
    chk("mid_rst_state", ramp_state, 0);
    chk("mid_rst_factor", ramp_factor, 0);
    chk("mid_rst_valid", dac_out_valid, 0);
    chk("mid_rst_dac_out", dac_out, 0);
    reset = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) run = ~run;
      if ($urandom_range(0, 29) == 0) srd = ~srd;
      if ($urandom_range(0, 99) == 0) en = ~en;
      if ($urandom_range(0, 59) == 0)
        case ($urandom_range(0, 3))
          0: step = 32'h0100_0000;
          1: step = $urandom;
          2: step = $urandom_range(1, 32'h0800_0000);
          default: step = 0;
        endcase
      reset = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    reset = 0; rand_data = 0; dac_in_valid = 0;
    tick(4);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dac_ramp_envelope.md
# dac_ramp_envelope

Per-channel DAC amplitude envelope stage that sits directly downstream of the reset manager. It consumes the manager's `ramping_enable`, `start_ramp_down` and synthesizer reset outputs. It produces a linear ramp-up / hold / ramp-down gain that scales the Fourier-synth sample stream before the DAC. It reports its state back to the manager's `ramp_state` inputs. One instance is used per DAC channel.

## Interface
Parameters:
- `STEP_WIDTH`, 32: width of the accumulator and the step. Full scale is `FULL = 2^(STEP_WIDTH-1)`.
- `DATA_WIDTH`, 16: signed sample width.

Ports:
- `clk`  in  1  ADC/DAC clock, 125 MHz.
- `reset`  in  1  synchronous, active-high reset.
- `enable_ramping`  in  1  from the reset manager `ramping_enable[n]`. 0 bypasses the envelope.
- `start_ramp_down`  in  1  from the reset manager `start_ramp_down[n]`. Level-sensitive.
- `run`  in  1  from the synth reset output `fourier_synth_aresetn_n`. High means the channel is active.
- `ramp_step`  in  STEP_WIDTH  unsigned increment added or subtracted per cycle.
- `dac_in`  in  DATA_WIDTH  signed sample.
- `dac_in_valid`  in  1  sample qualifier.
- `dac_out`  out  DATA_WIDTH  scaled sample.
- `dac_out_valid`  out  1  output qualifier.
- `ramp_state`  out  2  00 IDLE, 01 RAMP_UP, 10 HOLD, 11 RAMP_DOWN.
- `ramp_factor`  out  16  current gain in unsigned Q1.15. 0x8000 means 1.0.
- `ramp_done`  out  1  one-cycle pulse when a ramp-down completes.

## Operation
- Internal unsigned accumulator `acc`, STEP_WIDTH bits, range 0..FULL. `ramp_factor = acc[STEP_WIDTH-1 -: 16]` when enabled.
- Arming flag `armed`:
  - Set while `run == 0`.
  - Cleared on entry to RAMP_UP.
  - After a completed ramp, a new ramp requires `run` to fall and rise again.
- Bypass: `enable_ramping == 0` forces the state to IDLE, `acc = 0`, `ramp_factor = 0x8000` and `armed = 1`. The datapath still runs.
- FSM, evaluated when `enable_ramping == 1`:
  - IDLE → RAMP_UP when `run && armed && !start_ramp_down`. `acc` stays 0 on this edge.
  - RAMP_UP: `acc <= min(acc + ramp_step, FULL)`, computed with one extra carry bit so there is no wrap-around.
    - Go to HOLD on the edge where `acc` becomes FULL.
    - If `start_ramp_down` is high, go to RAMP_DOWN from the current `acc` with no increment on that edge. No gain step.
  - HOLD: `acc = FULL`. Go to RAMP_DOWN when `start_ramp_down` is high.
  - RAMP_DOWN: `acc <= (acc > ramp_step) ? acc - ramp_step : 0`. On the edge where `acc` becomes 0: go to IDLE and pulse `ramp_done` for 1 cycle.
  - `run == 0` in any non-IDLE state forces IDLE and `acc = 0` on the next edge. No `ramp_done`. This rule takes priority over `start_ramp_down`.
  - `ramp_step == 0`: `acc` holds and the state does not advance. This is legal.
  - `ramp_step >= FULL`: the ramp completes in 1 cycle.
- Datapath:
  - Stage 1: `prod = dac_in * {1'b0, ramp_factor}`, a signed 34-bit result. `ramp_factor` is sampled in the same cycle as `dac_in`.
  - Stage 2: `dac_out = prod >>> 15`, truncated toward −∞. No overflow is possible because the factor is ≤ 1.0.
  - `dac_out_valid` is `dac_in_valid` delayed 2 cycles. `dac_out` holds its value when valid is low.

## Timing
- Reset values:
  - `ramp_state = 00`, `acc = 0`, `ramp_factor = 0x0000`, `armed = 1`.
  - `ramp_done = 0`, `dac_out = 0`, `dac_out_valid = 0`, and both pipeline stages cleared.
- After reset is released with `enable_ramping == 0`, `ramp_factor` becomes 0x8000 on the first edge.
- Reset asserted mid-ramp takes effect on the next edge, overriding all other inputs.
- All outputs are registered.
  - `ramp_state`, `ramp_factor` and `ramp_done` update on the same edge as `acc`.
  - `dac_out` latency is 2 cycles from `dac_in`.
- Ramp duration is `ceil(FULL / ramp_step)` cycles in RAMP_UP, plus 1 cycle for the IDLE → RAMP_UP transition.
  - Example: `ramp_step = 0x0100_0000` gives 128 cycles, which is 1.024 µs at 125 MHz.
- Simultaneous events:
  - `start_ramp_down` together with `acc` reaching FULL: go to RAMP_DOWN, not HOLD.
  - `run` falling together with RAMP_DOWN completing: go to IDLE with no `ramp_done`.

## Test plan
- Step 0x0100_0000, `enable_ramping = 1`, `run` 0 → 1:
  - 1 cycle later the state is 01.
  - After 128 more cycles the state is 10 and `ramp_factor = 0x8000`.
  - `ramp_factor` is 0x0100 after the first increment.
- From HOLD, assert `start_ramp_down`:
  - State goes to 11, with factor 0x7F00 on the first decrement.
  - After 128 cycles the state is 00 and factor is 0.
  - `ramp_done` is high for exactly 1 cycle.
  - Holding `run` high does not restart the ramp; pulsing `run` low then high does.
- Abort mid-ramp:
  - `start_ramp_down` at factor 0x4000 goes to RAMP_DOWN and reaches 0 after 64 cycles.
  - `run` dropped at factor 0x4000 gives state 00, factor 0, and no `ramp_done` on the next edge.
- Datapath:
  - `dac_in = −32768` at factor 0x8000 gives −32768.
  - `dac_in = 1000` at factor 0x4000 gives 500.
  - `dac_in = −3` at factor 0x4000 gives −2.
  - Each result appears 2 cycles later, and valid is delayed by 2 cycles.
- Edge cases:
  - `ramp_step = 0xFFFF_FFFF` gives HOLD in one step.
  - `ramp_step = 0` with state 01 stays at 01 and factor 0.
  - `enable_ramping = 0` gives factor 0x8000 and state 00 immediately.
  - `reset` asserted during RAMP_UP gives all reset values on the next edge.
